uart_matrix_loader: RTL and testbench

Frame parser that sits directly downstream of the UART receiver. It consumes the received byte stream (`data`/`valid` strobes), synchronises on a header byte, and assembles two N×N 8-bit operand matrices, A and B, into register arrays. It validates each frame with an XOR checksum and presents the matrices to the multiplier core through a valid/ack handshake. Bad or stalled frames are discarded and reported.

---
 rtl/uart_matrix_loader.sv | 138 +++++++++++++
 tb/tb_uart_matrix_loader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_matrix_loader.sv
// Frame parser for UART byte streams.
// Waits for a sync byte, then loads two NxN byte matrices (A then B, row-major).
// A trailing XOR checksum byte validates the frame. A good frame is held until
// the consumer acknowledges it. Checksum errors and inter-byte stalls are
// reported with a one-cycle frame_err pulse.
module uart_matrix_loader #(
    parameter int unsigned N              = 2,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    input  logic               mat_ack,
    output logic [8*N*N-1:0]   mat_a,
    output logic [8*N*N-1:0]   mat_b,
    output logic               mat_valid,
    output logic               frame_err,
    output logic               overrun
);

    localparam int unsigned Elems = N * N;
    localparam int unsigned IdxW  = (Elems > 1) ? $clog2(Elems) : 1;
    localparam logic [IdxW-1:0] IdxLast = IdxW'(Elems - 1);
    localparam logic [31:0] TmoLast = TIMEOUT_CYCLES - 1;

    typedef enum logic [2:0] {StIdle, StLoadA, StLoadB, StCsum, StHold} state_e;

    state_e             state_q;
    logic [IdxW-1:0]    idx_q;
    logic [7:0]         acc_q;
    logic [31:0]        tmo_q;
    logic [8*Elems-1:0] mat_a_q;
    logic [8*Elems-1:0] mat_b_q;
    logic               mat_valid_q;
    logic               frame_err_q;
    logic               overrun_q;
    logic               tmo_hit;

    // The counter value this cycle would become the limit: give up on the frame.
    assign tmo_hit = ((tmo_q + 32'd1) == TmoLast);

    // Frame FSM with registered outputs, matrix storage and the inter-byte timer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            acc_q       <= '0;
            tmo_q       <= '0;
            mat_a_q     <= '0;
            mat_b_q     <= '0;
            mat_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            case (state_q)
                StIdle: begin
                    tmo_q <= '0;
                    if (rx_valid && (rx_data == SYNC_BYTE)) begin
                        state_q <= StLoadA;
                        idx_q   <= '0;
                        acc_q   <= '0;
                    end
                end
                StLoadA, StLoadB: begin
                    if (rx_valid) begin
                        tmo_q <= '0;
                        acc_q <= acc_q ^ rx_data;
                        for (int i = 0; i < Elems; i++) begin
                            if (idx_q == IdxW'(i)) begin
                                if (state_q == StLoadA) begin
                                    mat_a_q[8*i +: 8] <= rx_data;
                                end else begin
                                    mat_b_q[8*i +: 8] <= rx_data;
                                end
                            end
                        end
                        if (idx_q == IdxLast) begin
                            idx_q   <= '0;
                            state_q <= (state_q == StLoadA) ? StLoadB : StCsum;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else if (tmo_hit) begin
                        tmo_q       <= '0;
                        frame_err_q <= 1'b1;
                        state_q     <= StIdle;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                    end
                end
                StCsum: begin
                    if (rx_valid) begin
                        tmo_q <= '0;
                        if (rx_data == acc_q) begin
                            state_q     <= StHold;
                            mat_valid_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= StIdle;
                        end
                    end else if (tmo_hit) begin
                        tmo_q       <= '0;
                        frame_err_q <= 1'b1;
                        state_q     <= StIdle;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                    end
                end
                StHold: begin
                    tmo_q <= '0;
                    // Matrices are frozen here; any incoming byte is lost.
                    if (rx_valid) begin
                        overrun_q <= 1'b1;
                    end
                    if (mat_ack) begin
                        mat_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    mat_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign mat_a     = mat_a_q;
    assign mat_b     = mat_b_q;
    assign mat_valid = mat_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_matrix_loader.sv
// Self-checking bench for uart_matrix_loader (N=2, TIMEOUT_CYCLES=20).
module tb_uart_matrix_loader;

    localparam int N  = 2;
    localparam int NN = N * N;
    localparam int W  = 8 * NN;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         mat_ack;
    logic [W-1:0] mat_a;
    logic [W-1:0] mat_b;
    logic         mat_valid;
    logic         frame_err;
    logic         overrun;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         v;
        logic [7:0]   d;
        logic         ack;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic         ev;
        logic         ee;
        logic         eo;
    } vec_t;

    vec_t vecs[$];

    uart_matrix_loader #(
        .N              (N),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .mat_ack   (mat_ack),
        .mat_a     (mat_a),
        .mat_b     (mat_b),
        .mat_valid (mat_valid),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic [W-1:0] ea, input logic [W-1:0] eb,
                              input logic ev, input logic ee, input logic eo);
        check({name, " mat_a"}, mat_a, ea);
        check({name, " mat_b"}, mat_b, eb);
        check({name, " mat_valid"}, 32'(mat_valid), 32'(ev));
        check({name, " frame_err"}, 32'(frame_err), 32'(ee));
        check({name, " overrun"}, 32'(overrun), 32'(eo));
    endtask

    // Drive one clock cycle of inputs; returns at the next falling edge.
    task automatic cycle(input logic v, input logic [7:0] d, input logic ack);
        rx_valid = v;
        rx_data  = d;
        mat_ack  = ack;
        @(negedge clk);
        rx_valid = 1'b0;
        mat_ack  = 1'b0;
    endtask

    task automatic gap(input int maxgap);
        int n;
        n = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        repeat (n) cycle(1'b0, 8'h00, 1'b0);
    endtask

    function automatic logic [7:0] fold(input logic [W-1:0] w);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < NN; i++) x = x ^ w[8*i +: 8];
        return x;
    endfunction

    task automatic send_frame(input logic [W-1:0] aw, input logic [W-1:0] bw,
                              input logic [7:0] cs, input int maxgap);
        cycle(1'b1, 8'hA5, 1'b0);
        gap(maxgap);
        for (int i = 0; i < NN; i++) begin
            cycle(1'b1, aw[8*i +: 8], 1'b0);
            gap(maxgap);
        end
        for (int i = 0; i < NN; i++) begin
            cycle(1'b1, bw[8*i +: 8], 1'b0);
            gap(maxgap);
        end
        cycle(1'b1, cs, 1'b0);
    endtask

    task automatic add_vec(input logic v, input logic [7:0] d, input logic ack,
                           input logic [W-1:0] ea, input logic [W-1:0] eb,
                           input logic ev, input logic ee, input logic eo);
        vec_t x;
        x.v = v; x.d = d; x.ack = ack;
        x.ea = ea; x.eb = eb; x.ev = ev; x.ee = ee; x.eo = eo;
        vecs.push_back(x);
    endtask

    initial begin
        logic [W-1:0] aw, bw, ga;
        logic [7:0]   cs, g;
        int           first, errcnt;
        logic         bad;

        rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; mat_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_outs("reset", '0, '0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        // Good frame byte by byte, ack, then the same frame with a bad checksum.
        add_vec(1, 8'hA5, 0, 32'h00000000, 32'h00000000, 0, 0, 0);
        add_vec(1, 8'h01, 0, 32'h00000001, 32'h00000000, 0, 0, 0);
        add_vec(1, 8'h02, 0, 32'h00000201, 32'h00000000, 0, 0, 0);
        add_vec(1, 8'h03, 0, 32'h00030201, 32'h00000000, 0, 0, 0);
        add_vec(1, 8'h04, 0, 32'h04030201, 32'h00000000, 0, 0, 0);
        add_vec(1, 8'h05, 0, 32'h04030201, 32'h00000005, 0, 0, 0);
        add_vec(1, 8'h06, 0, 32'h04030201, 32'h00000605, 0, 0, 0);
        add_vec(1, 8'h07, 0, 32'h04030201, 32'h00070605, 0, 0, 0);
        add_vec(1, 8'h08, 0, 32'h04030201, 32'h08070605, 0, 0, 0);
        add_vec(1, 8'h08, 0, 32'h04030201, 32'h08070605, 1, 0, 0);
        add_vec(0, 8'h00, 0, 32'h04030201, 32'h08070605, 1, 0, 0);
        add_vec(0, 8'h00, 1, 32'h04030201, 32'h08070605, 0, 0, 0);
        add_vec(0, 8'h00, 1, 32'h04030201, 32'h08070605, 0, 0, 0);
        add_vec(1, 8'hA5, 0, 32'h04030201, 32'h08070605, 0, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            add_vec(1, 8'(i), 0, 32'h04030201, 32'h08070605, 0, 0, 0);
        end
        add_vec(1, 8'h09, 0, 32'h04030201, 32'h08070605, 0, 1, 0);
        add_vec(0, 8'h00, 0, 32'h04030201, 32'h08070605, 0, 0, 0);
        foreach (vecs[i]) begin
            cycle(vecs[i].v, vecs[i].d, vecs[i].ack);
            check_outs($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb,
                       vecs[i].ev, vecs[i].ee, vecs[i].eo);
        end

        // Garbage before sync is ignored; a sync value inside the data is data.
        cycle(1'b1, 8'h00, 1'b0);
        cycle(1'b1, 8'hFF, 1'b0);
        cycle(1'b1, 8'h5A, 1'b0);
        check("garbage valid", 32'(mat_valid), 32'd0);
        check("garbage err", 32'(frame_err), 32'd0);
        aw = 32'h3322A511;
        bw = 32'h77665544;
        send_frame(aw, bw, fold(aw) ^ fold(bw), 0);
        check_outs("sync-in-data", aw, bw, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        check("sync-in-data ack", 32'(mat_valid), 32'd0);

        // Inter-byte timeout after A5 01 02.
        cycle(1'b1, 8'hA5, 1'b0);
        cycle(1'b1, 8'h01, 1'b0);
        cycle(1'b1, 8'h02, 1'b0);
        first  = -1;
        errcnt = 0;
        for (int k = 1; k <= 30; k++) begin
            cycle(1'b0, 8'h00, 1'b0);
            if (frame_err) begin
                errcnt++;
                if (first < 0) first = k;
            end
        end
        check("timeout latency", 32'(first + 1), 32'd20);
        check("timeout pulse count", 32'(errcnt), 32'd1);
        check("timeout valid", 32'(mat_valid), 32'd0);

        // A byte arriving on the limit cycle keeps the frame alive.
        cycle(1'b1, 8'hA5, 1'b0);
        cycle(1'b1, 8'h10, 1'b0);
        repeat (18) cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b1, 8'h20, 1'b0);
        check("byte at limit err", 32'(frame_err), 32'd0);
        cycle(1'b0, 8'h00, 1'b0);
        check("byte at limit err+1", 32'(frame_err), 32'd0);
        aw = 32'h40302010;
        bw = 32'h80706050;
        cycle(1'b1, 8'h30, 1'b0);
        cycle(1'b1, 8'h40, 1'b0);
        for (int i = 0; i < NN; i++) cycle(1'b1, bw[8*i +: 8], 1'b0);
        cycle(1'b1, fold(aw) ^ fold(bw), 1'b0);
        check_outs("after timeout frame", aw, bw, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);

        // Overrun in HOLD, then ack together with a byte, then sync right after.
        aw = 32'hDEADBEEF;
        bw = 32'h12345678;
        send_frame(aw, bw, fold(aw) ^ fold(bw), 1);
        check_outs("hold", aw, bw, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 8'h33, 1'b0);
        check_outs("overrun1", aw, bw, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        check_outs("overrun1 end", aw, bw, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 8'h33, 1'b1);
        check_outs("overrun2 ack", aw, bw, 1'b0, 1'b0, 1'b1);
        ga = 32'hCAFEF00D;
        send_frame(ga, aw, fold(ga) ^ fold(aw), 0);
        check_outs("sync after ack", ga, aw, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);

        // Reset in the middle of a frame.
        cycle(1'b1, 8'hA5, 1'b0);
        for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0);
        rst = 1'b0;
        #1;
        check_outs("mid-frame reset", '0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_outs("mid-frame reset hold", '0, '0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        aw = 32'h04030201;
        bw = 32'h08070605;
        send_frame(aw, bw, 8'h08, 0);
        check_outs("post-reset frame", aw, bw, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);

        // Randomized frames against a byte-level model.
        for (int f = 0; f < 24; f++) begin
            repeat ($urandom_range(2, 0)) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h00;
                cycle(1'b1, g, 1'b0);
                check($sformatf("rnd%0d garbage valid", f), 32'(mat_valid), 32'd0);
            end
            aw  = $urandom;
            bw  = $urandom;
            cs  = fold(aw) ^ fold(bw);
            bad = ($urandom_range(3, 0) == 0);
            if (bad) cs = cs ^ 8'($urandom_range(255, 1));
            send_frame(aw, bw, cs, 3);
            if (bad) begin
                check_outs($sformatf("rnd%0d bad", f), aw, bw, 1'b0, 1'b1, 1'b0);
                cycle(1'b0, 8'h00, 1'b0);
                check($sformatf("rnd%0d err end", f), 32'(frame_err), 32'd0);
            end else begin
                check_outs($sformatf("rnd%0d good", f), aw, bw, 1'b1, 1'b0, 1'b0);
                repeat ($urandom_range(2, 0)) cycle(1'b0, 8'h00, 1'b0);
                check($sformatf("rnd%0d held", f), 32'(mat_valid), 32'd1);
                cycle(1'b0, 8'h00, 1'b1);
                check($sformatf("rnd%0d ack", f), 32'(mat_valid), 32'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
